// File: rtl/mux_bus_unit_if.sv
// External 8088-style multiplexed bus: address, AD bus halves, strobes, READY and HOLD/HLDA.
interface mux_bus_unit_if #(
  parameter int ADDR_W = 20
);
  logic [ADDR_W-1:0] a;
  logic [7:0]        ad_o;
  logic              ad_oe;
  logic [7:0]        ad_i;
  logic              ale;
  logic              rd_n;
  logic              wr_n;
  logic              den_n;
  logic              dtr;
  logic              iom_o;
  logic              ready;
  logic              hold;
  logic              hlda;

  modport master (
    output a, ad_o, ad_oe, ale, rd_n, wr_n, den_n, dtr, iom_o, hlda,
    input  ad_i, ready, hold
  );

  modport slave (
    input  a, ad_o, ad_oe, ale, rd_n, wr_n, den_n, dtr, iom_o, hlda,
    output ad_i, ready, hold
  );
endinterface

// File: rtl/mux_bus_unit.sv
// Bus interface unit: splits one core request into consecutive byte bus cycles
// (T1-T2-T3-[Tw]-T4) with READY wait states, wait timeout and HOLD/HLDA arbitration.
module mux_bus_unit #(
  parameter int ADDR_W    = 20,
  parameter int MAX_BYTES = 2,
  parameter int LEN_W     = $clog2(MAX_BYTES) + 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   we,
  input  logic                   iom,
  input  logic [LEN_W-1:0]       len,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [8*MAX_BYTES-1:0] wdata,
  output logic [8*MAX_BYTES-1:0] rdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  mux_bus_unit_if.master         bus
);

  localparam int WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WCNT_W-1:0] TO_V = WCNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4, S_HOLD
  } state_t;

  state_t                 state_q, state_d;
  logic [LEN_W-1:0]       idx_q, idx_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic                   we_q, we_d;
  logic                   iom_q, iom_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [8*MAX_BYTES-1:0] wdata_q, wdata_d;
  logic [8*MAX_BYTES-1:0] rdata_q, rdata_d;

  logic [ADDR_W-1:0] baddr;
  logic [7:0]        wbyte;
  logic              last;

  assign baddr = addr_q + ADDR_W'(idx_q);
  assign last  = (idx_q + LEN_W'(1) == len_q) || err_q;

  always_comb begin
    wbyte = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (idx_q == LEN_W'(i)) wbyte = wdata_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= LEN_W'(1);
      wcnt_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      iom_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      we_q    <= we_d;
      iom_q   <= iom_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    busy_d  = busy_q;
    err_d   = err_q;
    we_d    = we_q;
    iom_d   = iom_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.hold) begin
          state_d = S_HOLD;
        end else if (req) begin
          addr_d  = addr;
          we_d    = we;
          iom_d   = iom;
          wdata_d = wdata;
          if (len == '0)                          len_d = LEN_W'(1);
          else if (len > LEN_W'(MAX_BYTES))       len_d = LEN_W'(MAX_BYTES);
          else                                    len_d = len;
          rdata_d = '0;
          err_d   = 1'b0;
          idx_d   = '0;
          wcnt_d  = '0;
          busy_d  = 1'b1;
          state_d = S_T1;
        end
      end
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3, S_TW: begin
        // READY is checked before the timeout so a late READY still completes cleanly
        if (bus.ready) begin
          if (!we_q) begin
            for (int unsigned i = 0; i < MAX_BYTES; i++) begin
              if (idx_q == LEN_W'(i)) rdata_d[8*i +: 8] = bus.ad_i;
            end
          end
          state_d = S_T4;
        end else if ((TIMEOUT != 0) && (wcnt_q == TO_V)) begin
          err_d   = 1'b1;
          state_d = S_T4;
        end else begin
          wcnt_d  = wcnt_q + WCNT_W'(1);
          state_d = S_TW;
        end
      end
      S_T4: begin
        wcnt_d = '0;
        if (last) begin
          busy_d  = 1'b0;
          state_d = bus.hold ? S_HOLD : S_IDLE;
        end else begin
          idx_d   = idx_q + LEN_W'(1);
          state_d = bus.hold ? S_HOLD : S_T1;
        end
      end
      S_HOLD: begin
        if (!bus.hold) state_d = busy_q ? S_T1 : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.a     = '0;
    bus.ad_o  = '0;
    bus.ad_oe = 1'b0;
    bus.ale   = 1'b0;
    bus.rd_n  = 1'b1;
    bus.wr_n  = 1'b1;
    bus.den_n = 1'b1;
    bus.dtr   = 1'b1;
    bus.iom_o = 1'b0;
    bus.hlda  = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_T1: begin
        bus.a     = baddr;
        bus.ad_o  = baddr[7:0];
        bus.ad_oe = 1'b1;
        bus.ale   = 1'b1;
        bus.dtr   = we_q;
        bus.iom_o = iom_q;
      end
      S_T2, S_T3, S_TW: begin
        bus.a     = baddr;
        bus.dtr   = we_q;
        bus.iom_o = iom_q;
        bus.den_n = 1'b0;
        if (we_q) begin
          bus.wr_n  = 1'b0;
          bus.ad_o  = wbyte;
          bus.ad_oe = 1'b1;
        end else begin
          bus.rd_n  = 1'b0;
        end
      end
      S_T4: begin
        bus.a     = baddr;
        bus.dtr   = we_q;
        bus.iom_o = iom_q;
        if (we_q) begin
          bus.ad_o  = wbyte;
          bus.ad_oe = 1'b1;
        end
        done = last;
      end
      S_HOLD: bus.hlda = 1'b1;
      default: ;
    endcase
  end

  assign busy  = busy_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mux_bus_unit.sv
// Directed self-checking bench for mux_bus_unit (MAX_BYTES=2, TIMEOUT=4).
module tb_mux_bus_unit;
  localparam int ADDR_W    = 20;
  localparam int MAX_BYTES = 2;
  localparam int LEN_W     = 2;
  localparam int TIMEOUT   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req = 1'b0;
  logic              we  = 1'b0;
  logic              iom = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic [ADDR_W-1:0] addr = '0;
  logic [15:0]       wdata = '0;
  logic [15:0]       rdata;
  logic              busy, done, err;

  int errors = 0;
  int checks = 0;

  mux_bus_unit_if #(.ADDR_W(ADDR_W)) bus ();

  mux_bus_unit #(
    .ADDR_W(ADDR_W), .MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .iom(iom), .len(len),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .err(err), .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge; returns in the first cycle after accept.
  task automatic start(input logic w, input logic io, input logic [LEN_W-1:0] l,
                       input logic [ADDR_W-1:0] ad, input logic [15:0] wd);
    req = 1'b1; we = w; iom = io; len = l; addr = ad; wdata = wd;
    tick();
    req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.ready = 1'b1; bus.hold = 1'b0; bus.ad_i = 8'h00;
    tick(); tick();
    checks++; if (bus.a !== 20'h0 || bus.ad_o !== 8'h00 || bus.ad_oe !== 1'b0 || bus.ale !== 1'b0) begin
      errors++; $display("FAIL reset_addr: a=%h ad_o=%h ad_oe=%b ale=%b want 0/0/0/0", bus.a, bus.ad_o, bus.ad_oe, bus.ale); end
    checks++; if ({bus.rd_n, bus.wr_n, bus.den_n, bus.dtr, bus.iom_o, bus.hlda} !== 6'b111100) begin
      errors++; $display("FAIL reset_strobes: got %b want 111100", {bus.rd_n, bus.wr_n, bus.den_n, bus.dtr, bus.iom_o, bus.hlda}); end
    checks++; if ({busy, done, err} !== 3'b000 || rdata !== 16'h0) begin
      errors++; $display("FAIL reset_core: busy/done/err=%b rdata=%h want 000/0000", {busy, done, err}, rdata); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_read1();
    bus.ready = 1'b1;
    start(1'b0, 1'b1, 2'd1, 20'h12345, 16'h0);
    checks++; if (bus.ale !== 1'b1 || bus.a !== 20'h12345 || bus.ad_o !== 8'h45 || bus.ad_oe !== 1'b1) begin
      errors++; $display("FAIL rd1_t1: ale=%b a=%h ad_o=%h oe=%b want 1/12345/45/1", bus.ale, bus.a, bus.ad_o, bus.ad_oe); end
    checks++; if (bus.dtr !== 1'b0 || bus.iom_o !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL rd1_t1_ctl: dtr=%b iom_o=%b busy=%b want 0/1/1", bus.dtr, bus.iom_o, busy); end
    tick();
    checks++; if (bus.rd_n !== 1'b0 || bus.den_n !== 1'b0 || bus.ad_oe !== 1'b0 || bus.ale !== 1'b0) begin
      errors++; $display("FAIL rd1_t2: rd_n=%b den_n=%b oe=%b ale=%b want 0/0/0/0", bus.rd_n, bus.den_n, bus.ad_oe, bus.ale); end
    bus.ad_i = 8'hA5;
    tick();
    checks++; if (bus.rd_n !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rd1_t3: rd_n=%b done=%b want 0/0", bus.rd_n, done); end
    tick();
    checks++; if (done !== 1'b1 || rdata !== 16'h00A5 || err !== 1'b0 || bus.rd_n !== 1'b1) begin
      errors++; $display("FAIL rd1_done: done=%b rdata=%h err=%b rd_n=%b want 1/00a5/0/1", done, rdata, err, bus.rd_n); end
    bus.ad_i = 8'h00;
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || rdata !== 16'h00A5) begin
      errors++; $display("FAIL rd1_after: done=%b busy=%b rdata=%h want 0/0/00a5", done, busy, rdata); end
  endtask

  task automatic test_write_waits();
    logic [ADDR_W-1:0] ea;
    logic [7:0]        ed;
    int pos, b;
    bus.ready = 1'b0;
    start(1'b1, 1'b0, 2'd2, 20'h00400, 16'hBEEF);
    for (int c = 1; c <= 12; c++) begin
      pos = (c - 1) % 6;
      b   = (c - 1) / 6;
      ea  = (b == 0) ? 20'h00400 : 20'h00401;
      ed  = (b == 0) ? 8'hEF : 8'hBE;
      checks++; if (bus.a !== ea || bus.ale !== (pos == 0)) begin
        errors++; $display("FAIL wr_addr c%0d: a=%h ale=%b want %h/%b", c, bus.a, bus.ale, ea, pos == 0); end
      checks++; if (bus.wr_n !== !(pos >= 1 && pos <= 4) || done !== (c == 12)) begin
        errors++; $display("FAIL wr_strobe c%0d: wr_n=%b done=%b", c, bus.wr_n, done); end
      if (pos >= 1) begin
        checks++; if (bus.ad_o !== ed || bus.ad_oe !== 1'b1 || bus.dtr !== 1'b1) begin
          errors++; $display("FAIL wr_data c%0d: ad_o=%h oe=%b dtr=%b want %h/1/1", c, bus.ad_o, bus.ad_oe, bus.dtr, ed); end
      end else begin
        checks++; if (bus.ad_o !== ea[7:0]) begin
          errors++; $display("FAIL wr_t1_ad c%0d: ad_o=%h want %h", c, bus.ad_o, ea[7:0]); end
      end
      bus.ready = (pos == 4);
      if (c < 12) tick();
    end
    checks++; if (err !== 1'b0) begin
      errors++; $display("FAIL wr_err: err=%b want 0", err); end
    bus.ready = 1'b1;
    tick();
  endtask

  task automatic test_hold();
    bus.ready = 1'b1;
    start(1'b0, 1'b0, 2'd2, 20'h20010, 16'h0);
    tick();
    bus.hold = 1'b1; bus.ad_i = 8'h11;
    tick(); tick();
    checks++; if (done !== 1'b0 || bus.a !== 20'h20010) begin
      errors++; $display("FAIL hold_b0_t4: done=%b a=%h want 0/20010", done, bus.a); end
    for (int c = 5; c <= 9; c++) begin
      tick();
      checks++; if (bus.hlda !== 1'b1 || bus.ad_oe !== 1'b0 || bus.ale !== 1'b0 || bus.rd_n !== 1'b1 || busy !== 1'b1) begin
        errors++; $display("FAIL hold_c%0d: hlda=%b oe=%b ale=%b rd_n=%b busy=%b want 1/0/0/1/1", c, bus.hlda, bus.ad_oe, bus.ale, bus.rd_n, busy); end
    end
    bus.hold = 1'b0;
    tick();
    checks++; if (bus.hlda !== 1'b0 || bus.ale !== 1'b1 || bus.a !== 20'h20011) begin
      errors++; $display("FAIL hold_resume: hlda=%b ale=%b a=%h want 0/1/20011", bus.hlda, bus.ale, bus.a); end
    tick();
    bus.ad_i = 8'h22;
    tick(); tick();
    checks++; if (done !== 1'b1 || rdata !== 16'h2211) begin
      errors++; $display("FAIL hold_rdata: done=%b rdata=%h want 1/2211", done, rdata); end
    tick();
  endtask

  task automatic test_timeout();
    int lat;
    bus.ready = 1'b0; bus.ad_i = 8'hCC;
    start(1'b0, 1'b0, 2'd1, 20'h00055, 16'h0);
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      if (done === 1'b1) lat = c;
      else tick();
    end
    checks++; if (lat != 8) begin
      errors++; $display("FAIL to_latency: done at cycle %0d want 8", lat); end
    checks++; if (err !== 1'b1 || rdata !== 16'h0 || bus.rd_n !== 1'b1) begin
      errors++; $display("FAIL to_result: err=%b rdata=%h rd_n=%b want 1/0000/1", err, rdata, bus.rd_n); end
    tick();
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL to_hold_err: err=%b busy=%b want 1/0", err, busy); end
    // Ready arrives on the very edge where the timeout would fire.
    bus.ad_i = 8'h5A;
    start(1'b0, 1'b0, 2'd1, 20'h00056, 16'h0);
    checks++; if (err !== 1'b0) begin
      errors++; $display("FAIL to_err_clear: err=%b want 0", err); end
    for (int c = 1; c <= 7; c++) begin
      bus.ready = (c == 7);
      tick();
    end
    checks++; if (done !== 1'b1 || err !== 1'b0 || rdata !== 16'h005A) begin
      errors++; $display("FAIL to_ready_wins: done=%b err=%b rdata=%h want 1/0/005a", done, err, rdata); end
    bus.ready = 1'b1;
    tick();
  endtask

  task automatic test_wrap_len();
    int lat;
    bus.ready = 1'b1; bus.ad_i = 8'h33;
    start(1'b0, 1'b0, 2'd2, 20'hFFFFF, 16'h0);
    checks++; if (bus.a !== 20'hFFFFF) begin
      errors++; $display("FAIL wrap_a0: a=%h want fffff", bus.a); end
    tick(); tick(); tick(); tick();
    checks++; if (bus.a !== 20'h00000 || bus.ale !== 1'b1 || bus.ad_o !== 8'h00) begin
      errors++; $display("FAIL wrap_a1: a=%h ale=%b ad_o=%h want 00000/1/00", bus.a, bus.ale, bus.ad_o); end
    bus.ad_i = 8'h44;
    tick(); tick(); tick();
    checks++; if (done !== 1'b1 || rdata !== 16'h4433) begin
      errors++; $display("FAIL wrap_rdata: done=%b rdata=%h want 1/4433", done, rdata); end
    tick();
    // len=0 behaves as one byte, len=3 clamps to two.
    start(1'b0, 1'b0, 2'd0, 20'h00100, 16'h0);
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      if (done === 1'b1) lat = c;
      else tick();
    end
    checks++; if (lat != 4) begin
      errors++; $display("FAIL len0: done at cycle %0d want 4", lat); end
    tick();
    start(1'b0, 1'b0, 2'd3, 20'h00100, 16'h0);
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      if (done === 1'b1) lat = c;
      else tick();
    end
    checks++; if (lat != 8) begin
      errors++; $display("FAIL len_clamp: done at cycle %0d want 8", lat); end
    tick();
  endtask

  task automatic test_hold_priority();
    bus.hold = 1'b1; req = 1'b1; we = 1'b0; len = 2'd1; addr = 20'h00777;
    tick();
    checks++; if (bus.hlda !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL hp_hold: hlda=%b busy=%b want 1/0", bus.hlda, busy); end
    bus.hold = 1'b0;
    tick();
    checks++; if (bus.hlda !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL hp_release: hlda=%b busy=%b want 0/0", bus.hlda, busy); end
    tick();
    req = 1'b0;
    checks++; if (busy !== 1'b1 || bus.a !== 20'h00777 || bus.ale !== 1'b1) begin
      errors++; $display("FAIL hp_accept: busy=%b a=%h ale=%b want 1/00777/1", busy, bus.a, bus.ale); end
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.ready = 1'b0;
    start(1'b1, 1'b0, 2'd1, 20'h00200, 16'h0077);
    tick(); tick(); tick();
    checks++; if (bus.wr_n !== 1'b0) begin
      errors++; $display("FAIL rm_tw: wr_n=%b want 0", bus.wr_n); end
    rst = 1'b0;
    tick();
    checks++; if (bus.wr_n !== 1'b1 || bus.ad_oe !== 1'b0 || bus.a !== 20'h0 || bus.dtr !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rm_reset: wr_n=%b oe=%b a=%h dtr=%b busy=%b done=%b", bus.wr_n, bus.ad_oe, bus.a, bus.dtr, busy, done); end
    rst = 1'b1; bus.ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin
      errors++; $display("FAIL rm_no_done: %0d done pulses want 0", seen); end
    bus.ad_i = 8'h9C;
    start(1'b0, 1'b0, 2'd1, 20'h00300, 16'h0);
    tick(); tick(); tick();
    checks++; if (done !== 1'b1 || rdata !== 16'h009C) begin
      errors++; $display("FAIL rm_new_req: done=%b rdata=%h want 1/009c", done, rdata); end
    tick();
  endtask

  initial begin
    test_reset();
    test_read1();
    test_write_waits();
    test_hold();
    test_timeout();
    test_wrap_len();
    test_hold_priority();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
